pipe_stage: RTL and testbench
=============================

# pipe_stage

Parametrised, elastic pipeline stage register for the pipelined RISC-V core, replacing the fixed three-flop IF/ID latch.
- Carries an arbitrary-width payload with a valid/ready handshake, synchronous flush (bubble insertion) and an optional two-entry skid buffer, so upstream ready is fully registered.
- Counts back-pressure cycles for stall profiling.
- Instantiated between every pair of stages (IF/ID, ID/EX, EX/MEM, MEM/WB) with a stage-specific payload struct.

## Interface
Parameters:
- WIDTH, 32: payload width in bits.
- RESET_DATA, '0: value `out_data` takes on reset and flush. IF/ID uses `NOP_INSTR` in the instr field.
- SKID, 1: 1 = two-entry skid buffer with registered `in_ready`; 0 = single register with combinational `in_ready`.
- CNTW, 16: width of the stall counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high; clears all state.
- flush  input  1  synchronous kill of all held and incoming entries.
- in_valid  input  1  upstream has a payload.
- in_ready  output  1  stage can accept this cycle.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  stage holds a payload for downstream.
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  WIDTH  head payload.
- stall_cnt  output  CNTW  saturating count of cycles with `out_valid && !out_ready`.

## Operation
Handshake events:
- in_fire = `in_valid && in_ready`.
- out_fire = `out_valid && out_ready`.
- `out_valid` never drops without an out_fire or a flush.
- `out_data` is stable while `out_valid && !out_ready`.

SKID=0:
- `in_ready = !out_valid || out_ready`.
- On in_fire, the main register loads `in_data` and `out_valid` is set.
- On out_fire without in_fire, `out_valid` clears.

SKID=1:
- State is encoded by {main_v, skid_v}: EMPTY {0,0}, ONE {1,0}, FULL {1,1}.
- `in_ready` is a flop equal to `!skid_v`.
- EMPTY: in_fire → ONE; main ← in_data.
- ONE: in_fire && out_fire → ONE; main ← in_data.
- ONE: in_fire && !out_fire → FULL; skid ← in_data.
- ONE: out_fire && !in_fire → EMPTY.
- FULL: out_fire → ONE; main ← skid. No accept is possible, since `in_ready` = 0.
- Order is always preserved: the skid entry is never presented ahead of main.

Flush:
- Highest priority over every other event in the same cycle.
- Next edge: main_v = skid_v = 0, `out_data` ← RESET_DATA, `in_ready` ← 1.
- A simultaneous in_fire is discarded.
- A simultaneous out_fire still counts as consumed downstream. The stage does not re-present it.

Invalid payload:
- When `out_valid` = 0, `out_data` equals RESET_DATA. Main data is only written on load, reset or flush.

stall_cnt:
- Increments each cycle `out_valid && !out_ready && !flush`.
- Saturates at 2^CNTW−1.
- Cleared only by reset; flush does not clear it.

## Timing
Reset values:
- `out_valid` = 0.
- `out_data` = RESET_DATA.
- `in_ready` = 1 (SKID=1); for SKID=0 it follows its equation and is 1 after reset.
- `stall_cnt` = 0.
- Skid register = RESET_DATA.

Latency:
- 1 cycle from in_fire to `out_valid`.
- Throughput is 1 payload/cycle while `out_ready` stays high.

Back-pressure (SKID=1):
- `in_ready` deasserts the cycle after the skid fills.
- It reasserts the cycle after a FULL→ONE out_fire.

Reset and flush mid-operation:
- Reset asserted mid-transfer clears everything immediately (asynchronous).
- The first accept is possible on the first edge after deassertion.
- Flush latency is 1 edge; `out_valid` is 0 in the following cycle.

## Structure
Package `pipe_pkg`:
- `NOP_INSTR` = 32'h0000_0013.
- Payload structs `if_id_t` {instr, pc, pcplus4}, `id_ex_t`, `ex_mem_t`, `mem_wb_t`.
- Stages pass `$bits(<struct>)` as WIDTH.

Sub-module:
- One natural sub-module: `flopenrc`, a WIDTH-parametrised flop with enable, async reset and synchronous clear to a parameter value.
- Used for the main and skid entries.
- Valid bits and the counter are local logic.

## Test plan
- **Reset:** hold reset 3 cycles with in_valid=1, in_data=32'hDEADBEEF → out_valid=0, out_data=32'h13 (RESET_DATA=NOP_INSTR), stall_cnt=0.
- **Streaming:** stream 8 payloads 1..8 with out_ready=1 → out_data=1..8 on consecutive cycles, each one cycle after its accept; in_ready constant 1.
- **Skid fill (SKID=1):** out_ready=0, send A then B → A held on out_data, B in skid, in_ready=0 the cycle after B. Raise out_ready → A, B delivered in order, in_ready=1 the cycle after B.
- **Flush when full:** flush in FULL with simultaneous in_valid=1 (C) → next cycle out_valid=0, in_ready=1, out_data=RESET_DATA; C never appears.
- **Stall counter:** out_valid=1, out_ready=0 for 5 cycles → stall_cnt=5. With CNTW=3, hold 10 cycles → stall_cnt saturates at 7.
- **SKID=0 variant:** out_ready=0 while holding A → in_ready=0 combinationally. Raise out_ready with in_valid (D) in the same cycle → A consumed, D loaded, no gap.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the pipelined core: stage payload structs, the NOP
// encoding used to fill empty instruction slots, and the elastic-stage
// occupancy encoding.
package pipe_pkg;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pcplus4;
  } if_id_t;

  typedef struct packed {
    logic        reg_write;
    logic [1:0]  result_src;
    logic        mem_write;
    logic        jump;
    logic        branch;
    logic [2:0]  alu_ctrl;
    logic        alu_src;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm_ext;
    logic [31:0] pcplus4;
  } id_ex_t;

  typedef struct packed {
    logic        reg_write;
    logic [1:0]  result_src;
    logic        mem_write;
    logic [31:0] alu_result;
    logic [31:0] write_data;
    logic [4:0]  rd;
    logic [31:0] pcplus4;
  } ex_mem_t;

  typedef struct packed {
    logic        reg_write;
    logic [1:0]  result_src;
    logic [31:0] alu_result;
    logic [31:0] read_data;
    logic [4:0]  rd;
    logic [31:0] pcplus4;
  } mem_wb_t;

  // Reset/flush image for the IF/ID register: a NOP with zero PCs.
  localparam if_id_t IF_ID_RESET = '{instr: NOP_INSTR, pc: '0, pcplus4: '0};

  // Occupancy encoded as {main_v, skid_v}.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b10,
    ST_FULL  = 2'b11
  } skid_state_e;

endpackage

// File: rtl/flopenrc.sv
// Enabled register with asynchronous reset and synchronous clear, both
// returning to RESET_VAL. Clear wins over enable.
module flopenrc #(
  parameter int unsigned       WIDTH     = 32,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  // Next value: clear, load, or hold.
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = RESET_VAL;
    end else if (en) begin
      q_d = d;
    end
  end

  // Storage with asynchronous reset to the reset image.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= RESET_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/pipe_stage.sv
// Elastic pipeline stage register with valid/ready handshake, synchronous
// flush, optional two-entry skid buffer (registered in_ready) and a
// saturating back-pressure counter for stall profiling.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_DATA = '0,
  parameter bit               SKID       = 1'b1,
  parameter int unsigned      CNTW       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNTW-1:0]  stall_cnt
);

  skid_state_e      state_q, state_d;
  logic             in_fire;
  logic             out_fire;
  logic             main_en;
  logic             skid_en;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic [CNTW-1:0]  stall_cnt_d;
  logic [CNTW-1:0]  stall_cnt_q;

  assign out_valid = (state_q == ST_ONE) || (state_q == ST_FULL);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  // Occupancy register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next occupancy and data-path steering; flush overrides every event.
  // With SKID=0 in_ready forces out_fire whenever ONE accepts, so FULL is
  // unreachable and the same table serves both configurations.
  always_comb begin
    state_d = state_q;
    main_en = 1'b0;
    skid_en = 1'b0;
    main_d  = in_data;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d = ST_ONE;
            main_en = 1'b1;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_en = 1'b1;
          end else if (in_fire) begin
            state_d = ST_FULL;
            skid_en = 1'b1;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            state_d = ST_ONE;
            main_en = 1'b1;
            main_d  = skid_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  flopenrc #(
    .WIDTH    (WIDTH),
    .RESET_VAL(RESET_DATA)
  ) u_main (
    .clk  (clk),
    .reset(reset),
    .en   (main_en),
    .clr  (flush),
    .d    (main_d),
    .q    (main_q)
  );

  flopenrc #(
    .WIDTH    (WIDTH),
    .RESET_VAL(RESET_DATA)
  ) u_skid (
    .clk  (clk),
    .reset(reset),
    .en   (skid_en),
    .clr  (flush),
    .d    (in_data),
    .q    (skid_q)
  );

  // An emptied main entry keeps its old bits, so mask it to the reset image.
  assign out_data = out_valid ? main_q : RESET_DATA;

  generate
    if (SKID) begin : g_skid
      logic in_ready_d;
      logic in_ready_q;

      // Ready for next cycle: low only while the skid slot will be occupied.
      always_comb begin
        in_ready_d = (state_d != ST_FULL);
      end

      // Registered upstream ready.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          in_ready_q <= 1'b1;
        end else begin
          in_ready_q <= in_ready_d;
        end
      end

      assign in_ready = in_ready_q;
    end else begin : g_noskid
      assign in_ready = !out_valid || out_ready;
    end
  endgenerate

  // Saturating count of back-pressured cycles; flush cycles are not counted.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && !flush && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNTW'(1);
    end
  end

  // Stall counter register, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage.sv
module tb_pipe_stage;
  import pipe_pkg::*;

  logic        clk;
  logic        rst;

  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [31:0] a_in_data, a_out_data;
  logic [15:0] a_stall_cnt;

  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [31:0] b_in_data, b_out_data;
  logic [2:0]  b_stall_cnt;

  int unsigned checks;
  int unsigned failures;

  logic [31:0] exp_a[$];
  logic [31:0] exp_b[$];

  pipe_stage #(
    .WIDTH(32), .RESET_DATA(NOP_INSTR), .SKID(1'b1), .CNTW(16)
  ) dut_a (
    .clk(clk), .reset(rst), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .stall_cnt(a_stall_cnt)
  );

  pipe_stage #(
    .WIDTH(32), .RESET_DATA(NOP_INSTR), .SKID(1'b0), .CNTW(3)
  ) dut_b (
    .clk(clk), .reset(rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .stall_cnt(b_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: sampled mid-cycle, each out_fire pops the next expected payload.
  always @(negedge clk) begin
    if (!rst) begin
      if (a_out_valid && a_out_ready) begin
        if (exp_a.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL a_unexpected_out actual=%h required=none", a_out_data);
        end else begin
          chk("a_out_data", a_out_data, exp_a.pop_front());
        end
      end else if (!a_out_valid) begin
        chk("a_idle_data", a_out_data, NOP_INSTR);
      end
      if (b_out_valid && b_out_ready) begin
        if (exp_b.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL b_unexpected_out actual=%h required=none", b_out_data);
        end else begin
          chk("b_out_data", b_out_data, exp_b.pop_front());
        end
      end else if (!b_out_valid) begin
        chk("b_idle_data", b_out_data, NOP_INSTR);
      end
    end
  end

  // One cycle of stimulus on stage A; accepted payloads go to the scoreboard.
  task automatic step_a(input logic v, input logic [31:0] d, input logic ordy, input logic fl);
    a_in_valid  = v;
    a_in_data   = d;
    a_out_ready = ordy;
    a_flush     = fl;
    @(negedge clk);
    if (v && a_in_ready && !fl && !rst) exp_a.push_back(d);
    @(posedge clk);
    #1;
    if (fl) exp_a.delete();
  endtask

  task automatic step_b(input logic v, input logic [31:0] d, input logic ordy, input logic fl);
    b_in_valid  = v;
    b_in_data   = d;
    b_out_ready = ordy;
    b_flush     = fl;
    @(negedge clk);
    if (v && b_in_ready && !fl && !rst) exp_b.push_back(d);
    @(posedge clk);
    #1;
    if (fl) exp_b.delete();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    a_flush = 1'b0; a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
    b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;

    // Reset held 3 cycles with a payload offered.
    for (int i = 0; i < 3; i++) step_a(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    chk("rst_a_out_valid", {31'b0, a_out_valid}, 32'd0);
    chk("rst_a_out_data", a_out_data, 32'h0000_0013);
    chk("rst_a_stall_cnt", {16'b0, a_stall_cnt}, 32'd0);
    chk("rst_a_in_ready", {31'b0, a_in_ready}, 32'd1);
    chk("rst_b_out_valid", {31'b0, b_out_valid}, 32'd0);
    chk("rst_b_in_ready", {31'b0, b_in_ready}, 32'd1);
    rst = 1'b0;

    // Streaming 1..8 with out_ready high.
    for (int i = 1; i <= 8; i++) begin
      step_a(1'b1, 32'(i), 1'b1, 1'b0);
      chk("stream_in_ready", {31'b0, a_in_ready}, 32'd1);
      chk("stream_out_valid", {31'b0, a_out_valid}, 32'd1);
      chk("stream_head", a_out_data, 32'(i));
    end
    step_a(1'b0, '0, 1'b1, 1'b0);
    chk("stream_drained", {31'b0, a_out_valid}, 32'd0);

    // Skid fill: A then B with out_ready low.
    step_a(1'b1, 32'hAAAA_0001, 1'b0, 1'b0);
    chk("skid_a_head", a_out_data, 32'hAAAA_0001);
    chk("skid_ready_one", {31'b0, a_in_ready}, 32'd1);
    step_a(1'b1, 32'hBBBB_0002, 1'b0, 1'b0);
    chk("skid_ready_full", {31'b0, a_in_ready}, 32'd0);
    chk("skid_a_held", a_out_data, 32'hAAAA_0001);
    step_a(1'b1, 32'hCCCC_0bad, 1'b0, 1'b0);
    chk("skid_blocked", {31'b0, a_in_ready}, 32'd0);
    chk("skid_a_still", a_out_data, 32'hAAAA_0001);
    step_a(1'b0, '0, 1'b1, 1'b0);
    chk("skid_b_head", a_out_data, 32'hBBBB_0002);
    chk("skid_ready_back", {31'b0, a_in_ready}, 32'd1);
    step_a(1'b0, '0, 1'b1, 1'b0);
    chk("skid_empty", {31'b0, a_out_valid}, 32'd0);

    // Flush while FULL with a payload offered.
    step_a(1'b1, 32'h1111_0001, 1'b0, 1'b0);
    step_a(1'b1, 32'h2222_0002, 1'b0, 1'b0);
    step_a(1'b1, 32'h3333_0c0c, 1'b0, 1'b1);
    chk("flush_out_valid", {31'b0, a_out_valid}, 32'd0);
    chk("flush_in_ready", {31'b0, a_in_ready}, 32'd1);
    chk("flush_out_data", a_out_data, 32'h0000_0013);
    step_a(1'b0, '0, 1'b1, 1'b0);
    step_a(1'b0, '0, 1'b1, 1'b0);

    // Flush in ONE with simultaneous in_fire and out_fire.
    step_a(1'b1, 32'h4444_0004, 1'b0, 1'b0);
    step_a(1'b1, 32'h5555_0005, 1'b1, 1'b1);
    chk("flush1_out_valid", {31'b0, a_out_valid}, 32'd0);
    step_a(1'b0, '0, 1'b1, 1'b0);
    // Stalled cycles so far: two in the skid test, one in the flush test.
    chk("stall_kept_by_flush", {16'b0, a_stall_cnt}, 32'd3);

    // Asynchronous reset mid-cycle while holding a payload.
    step_a(1'b1, 32'h6666_0006, 1'b0, 1'b0);
    a_in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", {31'b0, a_out_valid}, 32'd0);
    chk("async_rst_data", a_out_data, 32'h0000_0013);
    chk("async_rst_cnt", {16'b0, a_stall_cnt}, 32'd0);
    exp_a.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // First accept after reset, then 5 stalled cycles.
    step_a(1'b1, 32'h7777_0007, 1'b0, 1'b0);
    chk("post_rst_accept", a_out_data, 32'h7777_0007);
    for (int i = 0; i < 5; i++) step_a(1'b0, '0, 1'b0, 1'b0);
    chk("stall_cnt_5", {16'b0, a_stall_cnt}, 32'd5);
    step_a(1'b0, '0, 1'b1, 1'b0);
    chk("stall_cnt_hold", {16'b0, a_stall_cnt}, 32'd5);

    // SKID=0: combinational in_ready and gapless replace.
    step_b(1'b1, 32'hA000_000A, 1'b0, 1'b0);
    chk("b_in_ready_low", {31'b0, b_in_ready}, 32'd0);
    b_out_ready = 1'b1;
    #1;
    chk("b_in_ready_comb", {31'b0, b_in_ready}, 32'd1);
    step_b(1'b1, 32'hD000_000D, 1'b1, 1'b0);
    chk("b_no_gap_valid", {31'b0, b_out_valid}, 32'd1);
    chk("b_no_gap_data", b_out_data, 32'hD000_000D);

    // CNTW=3 saturation over 10 stalled cycles.
    for (int i = 1; i <= 10; i++) begin
      step_b(1'b0, '0, 1'b0, 1'b0);
      if (i == 6) chk("b_stall_6", {29'b0, b_stall_cnt}, 32'd6);
    end
    chk("b_stall_sat", {29'b0, b_stall_cnt}, 32'd7);
    step_b(1'b0, '0, 1'b1, 1'b0);

    // SKID=0 streaming and flush.
    for (int i = 0; i < 4; i++) begin
      step_b(1'b1, 32'h0B00_0000 + 32'(i), 1'b1, 1'b0);
      chk("b_stream_ready", {31'b0, b_in_ready}, 32'd1);
    end
    step_b(1'b0, '0, 1'b1, 1'b0);
    step_b(1'b1, 32'hE000_000E, 1'b0, 1'b0);
    step_b(1'b1, 32'hF000_000F, 1'b0, 1'b1);
    chk("b_flush_valid", {31'b0, b_out_valid}, 32'd0);
    chk("b_flush_ready", {31'b0, b_in_ready}, 32'd1);
    step_b(1'b0, '0, 1'b1, 1'b0);
    chk("b_stall_after_flush", {29'b0, b_stall_cnt}, 32'd7);

    chk("a_queue_empty", 32'(exp_a.size()), 32'd0);
    chk("b_queue_empty", 32'(exp_b.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
